// File: rtl/mult_div_unit_if.sv
// Decoder/hazard-side bundle for the execute-stage multiply/divide unit.
// The master side drives the controls and operands; the slave side returns HI/LO and stall info.
interface mult_div_unit_if;
   localparam int unsigned XLEN = 32;

   logic            start;
   logic [1:0]      op;
   logic            hilo_we;
   logic            hilo_sel;
   logic            cancel;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            stall_req;

   modport master (
      output start, op, hilo_we, hilo_sel, cancel, a, b,
      input  hi, lo, busy, stall_req
   );

   modport slave (
      input  start, op, hilo_we, hilo_sel, cancel, a, b,
      output hi, lo, busy, stall_req
   );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage mult/multu/div/divu unit owning the architectural HI/LO registers.
// Results are computed at launch, held pending, and committed after a fixed latency.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic           clk,
   input logic           reset_n,
   mult_div_unit_if.slave bus
);
   localparam int unsigned XLEN    = 32;
   localparam int unsigned DXLEN   = 2 * XLEN;
   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [XLEN-1:0]  r_hi, w_hi_nxt;
   logic [XLEN-1:0]  r_lo, w_lo_nxt;
   logic [XLEN-1:0]  r_pend_hi, w_pend_hi_nxt;
   logic [XLEN-1:0]  r_pend_lo, w_pend_lo_nxt;
   logic             r_pend_skip, w_pend_skip_nxt;

   logic             w_is_signed;
   logic             w_is_div;
   logic             w_start_ok;
   logic             w_we_ok;
   logic [DXLEN-1:0] w_a_ext;
   logic [DXLEN-1:0] w_b_ext;
   logic [DXLEN-1:0] w_prod;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [XLEN-1:0]  w_a_mag;
   logic [XLEN-1:0]  w_b_mag;
   logic [XLEN-1:0]  w_b_safe;
   logic [XLEN-1:0]  w_q_mag;
   logic [XLEN-1:0]  w_r_mag;
   logic [XLEN-1:0]  w_quot;
   logic [XLEN-1:0]  w_rem;
   logic             w_div_zero;
   logic [XLEN-1:0]  w_res_hi;
   logic [XLEN-1:0]  w_res_lo;

   assign w_is_signed = bus.op[0];
   assign w_is_div    = bus.op[1];
   assign w_start_ok  = bus.start & ~bus.cancel;
   assign w_we_ok     = bus.hilo_we & ~bus.cancel;

   // Sign-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
   assign w_a_ext = {{XLEN{w_is_signed & bus.a[XLEN-1]}}, bus.a};
   assign w_b_ext = {{XLEN{w_is_signed & bus.b[XLEN-1]}}, bus.b};
   assign w_prod  = w_a_ext * w_b_ext;

   // Divide on magnitudes, then restore signs: quotient truncates, remainder follows dividend.
   assign w_a_neg    = w_is_signed & bus.a[XLEN-1];
   assign w_b_neg    = w_is_signed & bus.b[XLEN-1];
   assign w_a_mag    = w_a_neg ? XLEN'(XLEN'(0) - bus.a) : bus.a;
   assign w_b_mag    = w_b_neg ? XLEN'(XLEN'(0) - bus.b) : bus.b;
   assign w_div_zero = (bus.b == '0);
   assign w_b_safe   = w_div_zero ? XLEN'(1) : w_b_mag;
   assign w_q_mag    = w_a_mag / w_b_safe;
   assign w_r_mag    = w_a_mag % w_b_safe;
   assign w_quot     = (w_a_neg ^ w_b_neg) ? XLEN'(XLEN'(0) - w_q_mag) : w_q_mag;
   assign w_rem      = w_a_neg ? XLEN'(XLEN'(0) - w_r_mag) : w_r_mag;

   assign w_res_hi = w_is_div ? w_rem  : w_prod[DXLEN-1:XLEN];
   assign w_res_lo = w_is_div ? w_quot : w_prod[XLEN-1:0];

   // State and architectural/pending registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_pend_hi   <= '0;
         r_pend_lo   <= '0;
         r_pend_skip <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hi        <= w_hi_nxt;
         r_lo        <= w_lo_nxt;
         r_pend_hi   <= w_pend_hi_nxt;
         r_pend_lo   <= w_pend_lo_nxt;
         r_pend_skip <= w_pend_skip_nxt;
      end
   end

   // Next-state: launch/mthi/mtlo in IDLE, count down and commit in RUN.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_hi_nxt        = r_hi;
      w_lo_nxt        = r_lo;
      w_pend_hi_nxt   = r_pend_hi;
      w_pend_lo_nxt   = r_pend_lo;
      w_pend_skip_nxt = r_pend_skip;

      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_pend_hi_nxt   = w_res_hi;
               w_pend_lo_nxt   = w_res_lo;
               w_pend_skip_nxt = w_is_div & w_div_zero;
               w_cnt_nxt       = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               w_state_nxt     = S_RUN;
            end else if (w_we_ok) begin
               if (bus.hilo_sel) begin
                  w_hi_nxt = bus.a;
               end else begin
                  w_lo_nxt = bus.a;
               end
            end
         end
         S_RUN: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
               if (!r_pend_skip) begin
                  w_hi_nxt = r_pend_hi;
                  w_lo_nxt = r_pend_lo;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;
   assign bus.busy      = (r_state == S_RUN);
   assign bus.stall_req = (r_state == S_RUN) | w_start_ok;
endmodule
